// File: rtl/alu32_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu32_ctrl_pkg
//   Shared definitions for the alu32 arbiter slice: controller state encoding,
//   alu32 opcode constants and bit positions of the {c,n,z,v} flag vector.
// ----------------------------------------------------------------------------
package alu32_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    // Flag vector is packed as {c, n, z, v}.
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu32.sv
// ----------------------------------------------------------------------------
// alu32
//   32-bit combinational ALU.
//   a, b   : operands
//   op     : opcode (see alu32_ctrl_pkg)
//   result : 32-bit result
//   flags  : {c, n, z, v}
//   For add, c is the carry out. For sub, c is the carry out of a + ~b + 1,
//   i.e. c=1 means no borrow (a >= b unsigned). c and v are 0 for logic ops.
// ----------------------------------------------------------------------------
module alu32
    import alu32_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [32:0] w_sum;
    logic        w_c;
    logic        w_v;

    always_comb begin
        w_sum  = '0;
        result = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op)
            OP_NOTA: result = ~a;
            OP_NOTB: result = ~b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ADD: begin
                w_sum  = {1'b0, a} + {1'b0, b};
                result = w_sum[31:0];
                w_c    = w_sum[32];
                w_v    = (a[31] == b[31]) && (w_sum[31] != a[31]);
            end
            OP_SUB: begin
                w_sum  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                result = w_sum[31:0];
                w_c    = w_sum[32];
                w_v    = (a[31] != b[31]) && (w_sum[31] != a[31]);
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_C] = w_c;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == 32'd0);
        flags[FLAG_V] = w_v;
    end

endmodule

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way priority arbiter, purely combinational.
//   req[1:0] : request vector
//   prio     : port that wins when both request
//   gnt[1:0] : one-hot grant (all zero when nobody requests)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // A lone request always wins; on a tie prio decides.
    assign gnt[0] = req[0] & (~req[1] | ~prio);
    assign gnt[1] = req[1] & (~req[0] |  prio);

endmodule

// File: rtl/alu32_arbiter.sv
// ----------------------------------------------------------------------------
// alu32_arbiter
//   Shares one alu32 between two requesters with round-robin arbitration.
//   clk, reset_n (sync, active low)
//   req{0,1}_valid/ready/op/a/b : request ports, valid/ready handshake
//   rsp_valid/ready/id/result/flags : registered response, tagged with id
//   busy       : controller not in IDLE
//   cnt0, cnt1 : responses delivered per port (wrap modulo 2^CNT_W)
//   Flow: IDLE (arbitrate, capture) -> EXEC (alu evaluates) -> RESP (hold).
// ----------------------------------------------------------------------------
module alu32_arbiter
    import alu32_ctrl_pkg::*;
#(
    parameter logic RR_INIT = 1'b0,
    parameter int   CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prio;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [31:0]      r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic [CNT_W-1:0] r_cnt [2];

    logic [1:0]  w_gnt;
    logic        w_accept;
    logic        w_rsp_fire;
    logic [31:0] w_alu_result;
    logic [3:0]  w_alu_flags;

    rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .prio (r_prio),
        .gnt  (w_gnt)
    );

    alu32 u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (r_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    // Ready depends only on state, valids and prio; rsp_ready is not involved.
    assign req0_ready = (r_state == IDLE) & w_gnt[0];
    assign req1_ready = (r_state == IDLE) & w_gnt[1];
    assign w_accept   = req0_ready | req1_ready;
    assign w_rsp_fire = (r_state == RESP) & r_rsp_valid & rsp_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (w_rsp_fire) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_prio       <= RR_INIT;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op <= w_gnt[1] ? req1_op : req0_op;
                r_a  <= w_gnt[1] ? req1_a  : req0_a;
                r_b  <= w_gnt[1] ? req1_b  : req0_b;
                r_id <= w_gnt[1];
            end
            if (r_state == EXEC) begin
                r_rsp_result <= w_alu_result;
                r_rsp_flags  <= w_alu_flags;
                r_rsp_id     <= r_id;
                r_rsp_valid  <= 1'b1;
            end
            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
                // The port just served yields priority to the other one.
                r_prio      <= ~r_rsp_id;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_cnt[gi] <= '0;
                end else if (w_rsp_fire && (r_rsp_id == gi[0])) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = (r_state != IDLE);
    assign cnt0       = r_cnt[0];
    assign cnt1       = r_cnt[1];

endmodule

// File: tb/tb_alu32_arbiter.sv
module tb_alu32_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, busy;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] cnt0, cnt1;

    // Narrow-counter instance sharing all inputs, used for the wrap check.
    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
    logic [31:0] s_rsp_result;
    logic [3:0]  s_rsp_flags;
    logic [3:0]  s_cnt0, s_cnt1;

    always #5 clk = ~clk;

    alu32_arbiter #(.RR_INIT(1'b0), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    alu32_arbiter #(.RR_INIT(1'b0), .CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_result(s_rsp_result), .rsp_flags(s_rsp_flags), .busy(s_busy),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp0  = 0;
    int exp1  = 0;

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;   // {c,n,z,v}
        string       name;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_cnt0"},   cnt0,   64'(exp0 & 16'hFFFF));
        chk({tag, "_cnt1"},   cnt1,   64'(exp1 & 16'hFFFF));
        chk({tag, "_s_cnt0"}, s_cnt0, 64'(exp0 & 4'hF));
        chk({tag, "_s_cnt1"}, s_cnt1, 64'(exp1 & 4'hF));
    endtask

    // Single lone-request transaction with rsp_ready held high.
    task automatic run_op(input vec_t v);
        int   waited;
        logic got;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.port == 1'b0) begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end else begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end
        waited = 0;
        got = 1'b0;
        while (!got && waited < 20) begin
            #1;
            got = v.port ? req1_ready : req0_ready;
            if (!got) begin
                @(negedge clk);
                waited++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: ready never rose within 20 cycles", v.name);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Operands are free to change once accepted.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'hDEADBEEF; req0_b = 32'hCAFEF00D; req0_op = ~v.op;
        req1_a = 32'hDEADBEEF; req1_b = 32'hCAFEF00D; req1_op = ~v.op;
        @(negedge clk);
        chk({v.name, "_exec_busy"},  busy, 1);
        chk({v.name, "_exec_valid"}, rsp_valid, 0);
        @(negedge clk);
        chk({v.name, "_valid"},  rsp_valid,  1);
        chk({v.name, "_result"}, rsp_result, v.res);
        chk({v.name, "_flags"},  rsp_flags,  v.flg);
        chk({v.name, "_id"},     rsp_id,     v.port);
        if (v.port) exp1++; else exp0++;
        @(negedge clk);
        chk({v.name, "_done_valid"}, rsp_valid, 0);
        chk_cnts(v.name);
        $display("txn %-10s port=%0d op=%03b a=%08h b=%08h -> result=%08h flags=%04b id=%0d cnt0=%0d cnt1=%0d",
                 v.name, v.port, v.op, v.a, v.b, rsp_result, rsp_flags, rsp_id, cnt0, cnt1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp0 = 0;
        exp1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nseen;
        logic exp_id;
        vec_t wv;

        vecs[0]  = '{1'b0, 3'b110, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, "add_ovf"};
        vecs[1]  = '{1'b1, 3'b000, 32'hFFFF0000, 32'h00FF00FF, 32'h0000FFFF, 4'b0000, "nota"};
        vecs[2]  = '{1'b1, 3'b001, 32'hFFFF0000, 32'h00FF00FF, 32'hFF00FF00, 4'b0100, "notb"};
        vecs[3]  = '{1'b1, 3'b010, 32'hFFFF0000, 32'h00FF00FF, 32'h00FF0000, 4'b0000, "and"};
        vecs[4]  = '{1'b1, 3'b011, 32'hFFFF0000, 32'h00FF00FF, 32'hFFFF00FF, 4'b0100, "or"};
        vecs[5]  = '{1'b1, 3'b100, 32'hFFFF0000, 32'h00FF00FF, 32'hFF0000FF, 4'b0100, "xor"};
        vecs[6]  = '{1'b1, 3'b101, 32'hFFFF0000, 32'h00FF00FF, 32'h00FFFF00, 4'b0000, "xnor"};
        vecs[7]  = '{1'b1, 3'b110, 32'hFFFF0000, 32'h00FF00FF, 32'h00FE00FF, 4'b1000, "add"};
        vecs[8]  = '{1'b1, 3'b111, 32'hFFFF0000, 32'h00FF00FF, 32'hFEFFFF01, 4'b1100, "sub"};
        vecs[9]  = '{1'b1, 3'b111, 32'h000000FF, 32'hFFFFFFFF, 32'h00000100, 4'b0000, "sub_borrow"};
        vecs[10] = '{1'b0, 3'b100, 32'h12345678, 32'h12345678, 32'h00000000, 4'b0010, "xor_zero"};
        vecs[11] = '{1'b1, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, "add_carry"};
        vecs[12] = '{1'b0, 3'b111, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1001, "sub_ovf"};

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  rsp_valid,  0);
        chk("rst_id",     rsp_id,     0);
        chk("rst_result", rsp_result, 0);
        chk("rst_flags",  rsp_flags,  0);
        chk("rst_busy",   busy,       0);
        chk_cnts("rst");
        reset_n = 1'b1;

        // Single op (leaves prio pointing at port 1)
        run_op(vecs[0]);

        // Reset in EXEC drops the transaction and restores prio
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b110; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        chk("midrst_accept", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("midrst_in_exec", busy, 1);
        reset_n = 1'b0;
        exp0 = 0;
        exp1 = 0;
        @(negedge clk);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_busy",  busy,      0);
        chk_cnts("midrst");
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        $display("txn midrst     reset in EXEC, response dropped, cnt0=%0d cnt1=%0d", cnt0, cnt1);

        // Tie after reset: port 0 first, then port 1
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 32'd5;       req0_b = 32'd5;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'h0000F0F0; req1_b = 32'h00000FF0;
        #1;
        chk("tie_rdy0", req0_ready, 1);
        chk("tie_rdy1", req1_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req0_a = 32'hDEADBEEF;
        @(negedge clk);
        chk("tie_exec_rdy1", req1_ready, 0);
        @(negedge clk);
        chk("tie_p0_id",     rsp_id,     0);
        chk("tie_p0_result", rsp_result, 32'h0);
        chk("tie_p0_flags",  rsp_flags,  4'b1010);
        exp0++;
        $display("txn tie_p0     id=%0d result=%08h flags=%04b", rsp_id, rsp_result, rsp_flags);
        @(negedge clk);
        #1;
        chk("tie_rdy1_next", req1_ready, 1);
        chk_cnts("tie_p0");
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tie_p1_id",     rsp_id,     1);
        chk("tie_p1_result", rsp_result, 32'h000000F0);
        chk("tie_p1_flags",  rsp_flags,  4'b0000);
        exp1++;
        $display("txn tie_p1     id=%0d result=%08h flags=%04b", rsp_id, rsp_result, rsp_flags);
        @(negedge clk);
        chk_cnts("tie_p1");

        // Four more tied requests must alternate 0,1,0,1
        req0_valid = 1'b1; req0_op = 3'b110; req0_a = 32'd1;     req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'h10;    req1_b = 32'h01;
        exp_id = 1'b0;
        nseen = 0;
        for (int i = 0; i < 60 && nseen < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("alt_id",     rsp_id,     exp_id);
                chk("alt_result", rsp_result, exp_id ? 32'h11 : 32'h3);
                $display("txn alt%0d       id=%0d result=%08h", nseen, rsp_id, rsp_result);
                if (exp_id) exp1++; else exp0++;
                exp_id = ~exp_id;
                nseen++;
                if (nseen == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        chk("alt_count", nseen, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk_cnts("alt");

        // Backpressure: response held for 10 cycles, both readies low
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'h00001234; req0_b = 32'h00AB0000;
        #1;
        chk("bp_accept", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'h0; req1_b = 32'h0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",  rsp_valid,  1);
            chk("bp_result", rsp_result, 32'h00AB1234);
            chk("bp_flags",  rsp_flags,  4'b0000);
            chk("bp_id",     rsp_id,     0);
            chk("bp_rdy0",   req0_ready, 0);
            chk("bp_rdy1",   req1_ready, 0);
            chk("bp_busy",   busy,       1);
            if (i < 9) @(negedge clk);
        end
        rsp_ready = 1'b1;
        exp0++;
        @(negedge clk);
        chk("bp_taken_valid", rsp_valid, 0);
        chk("bp_hold_result", rsp_result, 32'h00AB1234);
        chk_cnts("bp");
        $display("txn backpress  id=0 result=%08h held 10 cycles, taken on rsp_ready rise", rsp_result);
        #1;
        chk("bp_rdy1_after", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_p1_id",     rsp_id,     1);
        chk("bp_p1_result", rsp_result, 32'hFFFFFFFF);
        chk("bp_p1_flags",  rsp_flags,  4'b0100);
        exp1++;
        @(negedge clk);
        chk_cnts("bp_p1");
        $display("txn bp_p1      id=1 result=%08h", rsp_result);

        // Opcode sweep and flag corners
        for (int i = 1; i < 13; i++) run_op(vecs[i]);

        // Counter wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wv = '{1'b0, 3'b110, 32'(i), 32'd1, 32'(i + 1), 4'b0000, "wrap"};
            run_op(wv);
        end
        chk("wrap_s_cnt0", s_cnt0, 4'd1);
        chk("wrap_s_cnt1", s_cnt1, 4'd0);
        chk("wrap_cnt0",   cnt0,   16'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
